// File: rtl/icache_assoc.sv
// N-way set-associative, read-only instruction cache with an AXI4 burst refill port.
// Tag/valid/data live in internal arrays; a lookup takes one registered cycle and a miss refills a whole line.
module icache_assoc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              resp_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready
);

  localparam int BEATS    = LINE_BYTES * 8 / DATA_W;
  localparam int WORD_OFF = $clog2(DATA_W / 8);
  localparam int OFF_W    = $clog2(LINE_BYTES);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_W - IDX_W - OFF_W;
  localparam int BEAT_W   = OFF_W - WORD_OFF;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [BEAT_W:0] LAST_BEAT = (BEAT_W + 1)'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_AR, S_MISS_R, S_RESP, S_FLUSH
  } state_e;

  state_e state_q, state_d;

  // Storage arrays
  logic [DATA_W-1:0]   data_q  [NUM_WAYS][NUM_SETS][BEATS];
  logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
  logic [WAY_W-1:0]    rr_q    [NUM_SETS];

  // Request and refill bookkeeping
  logic [ADDR_W-1:0] addr_q;
  logic [WAY_W-1:0]  victim_q;
  logic [BEAT_W:0]   cnt_q;
  logic              err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [BEAT_W-1:0]   word_sel;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim_d;
  logic [WAY_W-1:0]    rr_next;
  logic                beat_fire;
  logic                last_fire;
  logic                refill_bad;
  logic                unused_lsbs;

  assign idx         = addr_q[OFF_W +: IDX_W];
  assign tag         = addr_q[ADDR_W-1 -: TAG_W];
  assign word_sel    = addr_q[WORD_OFF +: BEAT_W];
  assign unused_lsbs = ^addr_q[WORD_OFF-1:0];

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    assign hit_vec[gi] = valid_q[gi][idx] && (tag_q[gi][idx] == tag);
  end

  assign hit = |hit_vec;

  // Downward scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit_way  = '0;
    victim_d = rr_q[idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid_q[w][idx]) victim_d = WAY_W'(w);
    end
  end

  assign rr_next = (NUM_WAYS == 1) ? '0 : rr_q[idx] + 1'b1;

  assign beat_fire  = (state_q == S_MISS_R) && rvalid;
  assign last_fire  = beat_fire && rlast;
  assign refill_bad = err_q || (rresp != 2'b00) || (cnt_q != LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush)          state_d = S_FLUSH;
        else if (req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP:  state_d = hit ? S_RESP : S_MISS_AR;
      S_MISS_AR: if (arready) state_d = S_MISS_R;
      S_MISS_R:  if (rvalid && rlast) state_d = S_RESP;
      S_RESP:    if (resp_ready) state_d = S_IDLE;
      S_FLUSH:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    flush_done = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (state_q)
      S_IDLE:    req_ready  = ~flush & ~rst;
      S_MISS_AR: arvalid    = 1'b1;
      S_MISS_R:  rready     = 1'b1;
      S_RESP:    resp_valid = 1'b1;
      S_FLUSH:   flush_done = 1'b1;
      default:   ;
    endcase
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q & (state_q == S_RESP);
  assign araddr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign arlen     = 8'(BEATS - 1);
  assign arsize    = 3'(WORD_OFF);
  assign arburst   = 2'b01;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
      addr_q      <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) addr_q <= req_addr;
        end
        S_LOOKUP: begin
          if (hit) begin
            resp_data_q <= data_q[hit_way][idx][word_sel];
            resp_err_q  <= 1'b0;
          end else begin
            victim_q <= victim_d;
            cnt_q    <= '0;
            err_q    <= 1'b0;
          end
        end
        S_MISS_AR: begin
          // Invalidate the victim before any beat lands so a partial line never hits.
          if (arready) valid_q[victim_q][idx] <= 1'b0;
        end
        S_MISS_R: begin
          if (rvalid) begin
            cnt_q <= cnt_q + 1'b1;
            if (rresp != 2'b00) err_q <= 1'b1;
            if (cnt_q == {1'b0, word_sel}) resp_data_q <= rdata;
            if (rlast) begin
              if (refill_bad) begin
                resp_data_q <= '0;
                resp_err_q  <= 1'b1;
              end else begin
                valid_q[victim_q][idx] <= 1'b1;
                rr_q[idx]              <= rr_next;
                resp_err_q             <= 1'b0;
              end
            end
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Line data and tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (beat_fire && !cnt_q[BEAT_W]) data_q[victim_q][idx][cnt_q[BEAT_W-1:0]] <= rdata;
    if (last_fire && !refill_bad) tag_q[victim_q][idx] <= tag;
  end

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_LOOKUP) |-> $onehot0(hit_vec));

endmodule
